cpu_run_ctrl: RTL

Parametrised run/step/halt controller between the front panel and the SAP-1.5 CPU core. It gates the CPU clock enable and supports free-run, single-instruction step, HLT detection and a cycle-budget watchdog. Cycle and instruction counters are exposed for on-board debug and for benches. It replaces ad-hoc "run until halt" loops with a synthesizable equivalent that drives the `computer` clock enable.

---
 rtl/cpu_run_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt controller for the SAP-1.5 core: gates the CPU clock enable,
// detects HLT, enforces an enabled-cycle watchdog and exposes debug counters.
module cpu_run_ctrl #(
   parameter int CYCLE_W    = 16,
   parameter int INSTR_W    = 16,
   parameter int MAX_CYCLES = 100
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run_i,
   input  logic               step_i,
   input  logic               stop_i,
   input  logic               clr_i,
   input  logic               halt_i,
   input  logic               instr_done_i,
   output logic               cpu_clk_en_o,
   output logic [2:0]         state_o,
   output logic [CYCLE_W-1:0] cycle_count_o,
   output logic [INSTR_W-1:0] instr_count_o,
   output logic               halted_o,
   output logic               timeout_o
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_STEP    = 3'd2,
      ST_HALTED  = 3'd3,
      ST_TIMEOUT = 3'd4
   } state_t;

   localparam bit                 WD_EN   = (MAX_CYCLES != 0);
   localparam logic [CYCLE_W-1:0] WD_LAST = WD_EN ? CYCLE_W'(MAX_CYCLES - 1) : '0;
   localparam logic [CYCLE_W-1:0] CYC_SAT = '1;
   localparam logic [INSTR_W-1:0] INS_SAT = '1;

   state_t             state_q, state_d;
   logic [CYCLE_W-1:0] cycle_q, cycle_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               en;
   logic               wdog;

   assign en   = (state_q == ST_RUN) || (state_q == ST_STEP);
   // Fires on the last budgeted enabled cycle, so that cycle still executes.
   assign wdog = WD_EN && en && (cycle_q == WD_LAST);

   always_comb begin
      state_d = state_q;
      if (clr_i) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (run_i)       state_d = ST_RUN;
               else if (step_i) state_d = ST_STEP;
            end
            ST_RUN: begin
               if (halt_i)      state_d = ST_HALTED;
               else if (wdog)   state_d = ST_TIMEOUT;
               else if (stop_i) state_d = ST_IDLE;
            end
            ST_STEP: begin
               if (halt_i)            state_d = ST_HALTED;
               else if (wdog)         state_d = ST_TIMEOUT;
               else if (instr_done_i) state_d = ST_IDLE;
               else if (stop_i)       state_d = ST_IDLE;
            end
            ST_HALTED:  state_d = ST_HALTED;
            ST_TIMEOUT: state_d = ST_TIMEOUT;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      cycle_d = cycle_q;
      instr_d = instr_q;
      if (clr_i) begin
         cycle_d = '0;
         instr_d = '0;
      end else if (en) begin
         if (cycle_q != CYC_SAT)                instr_d = instr_q;
         if (cycle_q != CYC_SAT)                cycle_d = cycle_q + 1'b1;
         if (instr_done_i && instr_q != INS_SAT) instr_d = instr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cycle_q <= '0;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         cycle_q <= cycle_d;
         instr_q <= instr_d;
      end
   end

   assign cpu_clk_en_o  = en;
   assign state_o       = state_q;
   assign cycle_count_o = cycle_q;
   assign instr_count_o = instr_q;
   assign halted_o      = (state_q == ST_HALTED);
   assign timeout_o     = (state_q == ST_TIMEOUT);

endmodule
